// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - shared state encoding, default sizes and counter helper for mux2_arbiter
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MAX_BURST = 4;
    localparam int CNT_W             = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    // Beat counter sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mux2_bus.sv
// rtl/mux2_bus.sv - WIDTH+2 bit 2:1 mux carrying data, last and valid of one requester
module mux2_bus
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    input  logic             b_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             y_valid
);

    logic [WIDTH+1:0] a_bus;
    logic [WIDTH+1:0] b_bus;
    logic [WIDTH+1:0] y_bus;

    assign a_bus = {a_valid, a_last, a_data};
    assign b_bus = {b_valid, b_last, b_data};
    assign y_bus = sel ? b_bus : a_bus;
    assign {y_valid, y_last, y_data} = y_bus;

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - two-requester round-robin packet arbiter; optional MUX2_ARB_BURST_LIMIT_EN caps beats per grant
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic             rr;
    logic             rr_next;
    logic             sel_q;
    logic             sel_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_next;
    logic             bus_valid;
    logic             bus_last;
    logic [WIDTH-1:0] bus_data;
    logic             xfer;
    logic             other_valid;
    logic             burst_hit;
    logic             release_grant;

    mux2_bus #(.WIDTH(WIDTH)) u_bus (
        .sel     (sel_q),
        .a_data  (req0_data),
        .a_last  (req0_last),
        .a_valid (req0_valid),
        .b_data  (req1_data),
        .b_last  (req1_last),
        .b_valid (req1_valid),
        .y_data  (bus_data),
        .y_last  (bus_last),
        .y_valid (bus_valid)
    );

    // sel_q always equals n while in GRANTn, so the mux output is the owner's beat.
    assign busy        = (state != IDLE);
    assign sel         = sel_q;
    assign out_valid   = busy & bus_valid;
    assign out_data    = bus_data;
    assign out_last    = bus_last;
    assign req0_ready  = (state == GRANT0) & out_ready;
    assign req1_ready  = (state == GRANT1) & out_ready;
    assign xfer        = out_valid & out_ready;
    assign other_valid = sel_q ? req0_valid : req1_valid;

`ifdef MUX2_ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
    // Yield only on the beat that reaches the cap, and only if someone is waiting.
    assign burst_hit = (beat_cnt != BURST_CAP) && (sat_inc(beat_cnt) == BURST_CAP) && other_valid;
`else
    logic unused_cfg;
    assign burst_hit  = 1'b0;
    assign unused_cfg = ^{other_valid, beat_cnt, CNT_W'(MAX_BURST)};
`endif

    assign release_grant = xfer & (out_last | burst_hit);

    always_comb begin
        state_next    = state;
        rr_next       = rr;
        sel_next      = sel_q;
        beat_cnt_next = beat_cnt;
        case (state)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    if (rr == 1'b0) begin
                        sel_next = req0_valid ? 1'b0 : 1'b1;
                    end else begin
                        sel_next = req1_valid ? 1'b1 : 1'b0;
                    end
                    state_next    = sel_next ? GRANT1 : GRANT0;
                    beat_cnt_next = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (xfer) begin
                    beat_cnt_next = sat_inc(beat_cnt);
                end
                if (release_grant) begin
                    state_next = IDLE;
                    rr_next    = ~sel_q;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= 1'b0;
            sel_q    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            rr       <= rr_next;
            sel_q    <= sel_next;
            beat_cnt <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - directed and randomized checks of mux2_arbiter against a per-cycle reference model
module tb_mux2_arbiter;

    localparam int WIDTH = 8;
`ifdef MUX2_ARB_BURST_LIMIT_EN
    localparam int MAX_BURST = 2;
    localparam bit BURST_EN  = 1'b1;
`else
    localparam int MAX_BURST = 4;
    localparam bit BURST_EN  = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_last;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic             busy;

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tcyc;
    int vprob;
    int rprob;
    logic [31:0] ordy_pat;
    logic [31:0] vmask0;
    logic [31:0] vmask1;

    logic [WIDTH:0]   q0[$];
    logic [WIDTH:0]   q1[$];
    logic [WIDTH-1:0] exp0[$];
    logic [WIDTH-1:0] exp1[$];
    int               obs_src[$];
    logic [WIDTH-1:0] obs_data[$];
    int               obs_cyc[$];

    // Reference model: who owns the bus (-1 = nobody), who is favoured next, last select, beats in grant.
    int m_owner;
    int m_prefer;
    int m_sel;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_prefer = 0;
        m_sel    = 0;
        m_cnt    = 0;
    endtask

    task automatic clear_obs();
        obs_src.delete();
        obs_data.delete();
        obs_cyc.delete();
        tcyc = 0;
    endtask

    task automatic add_beat(input int src, input logic [WIDTH-1:0] data, input logic last, input bit scored);
        if (src == 0) begin
            q0.push_back({last, data});
            if (scored) exp0.push_back(data);
        end else begin
            q1.push_back({last, data});
            if (scored) exp1.push_back(data);
        end
    endtask

    function automatic bit pat_bit(input logic [31:0] pat);
        return pat[(tcyc > 31) ? 31 : tcyc];
    endfunction

    task automatic step();
        logic             v[2];
        logic             l[2];
        logic [WIDTH-1:0] d[2];
        int               pick;
        req0_valid = (q0.size() > 0) && pat_bit(vmask0) && ($urandom_range(99) < vprob);
        req1_valid = (q1.size() > 0) && pat_bit(vmask1) && ($urandom_range(99) < vprob);
        req0_data  = WIDTH'($urandom);
        req0_last  = 1'($urandom);
        req1_data  = WIDTH'($urandom);
        req1_last  = 1'($urandom);
        if (q0.size() > 0) {req0_last, req0_data} = q0[0];
        if (q1.size() > 0) {req1_last, req1_data} = q1[0];
        out_ready = pat_bit(ordy_pat) && ($urandom_range(99) < rprob);
        #2;
        v[0] = req0_valid; l[0] = req0_last; d[0] = req0_data;
        v[1] = req1_valid; l[1] = req1_last; d[1] = req1_data;
        if (m_owner < 0) begin
            check("idle_valid", out_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_rdy0", req0_ready, 0);
            check("idle_rdy1", req1_ready, 0);
            check("idle_sel", sel, m_sel);
        end else begin
            check("grant_busy", busy, 1);
            check("grant_sel", sel, m_owner);
            check("grant_valid", out_valid, v[m_owner]);
            check("grant_rdy0", req0_ready, (m_owner == 0) && out_ready);
            check("grant_rdy1", req1_ready, (m_owner == 1) && out_ready);
            if (v[m_owner]) begin
                check("grant_data", out_data, d[m_owner]);
                check("grant_last", out_last, l[m_owner]);
            end
        end
        if (out_valid && out_ready) begin
            obs_src.push_back(int'(sel));
            obs_data.push_back(out_data);
            obs_cyc.push_back(tcyc);
        end
        if (req0_valid && req0_ready && q0.size() > 0) void'(q0.pop_front());
        if (req1_valid && req1_ready && q1.size() > 0) void'(q1.pop_front());
        if (m_owner < 0) begin
            pick = v[m_prefer] ? m_prefer : (v[1-m_prefer] ? 1 - m_prefer : -1);
            if (pick >= 0) begin
                m_owner = pick;
                m_sel   = pick;
                m_cnt   = 0;
            end
        end else if (v[m_owner] && out_ready) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (l[m_owner] || (BURST_EN && m_cnt == MAX_BURST && v[1-m_owner])) begin
                m_prefer = 1 - m_owner;
                m_owner  = -1;
            end
        end
        @(posedge clk);
        #2;
        tcyc++;
    endtask

    initial begin
        int n0;
        int n1;
        int len;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        out_ready = 1'b0;
        vprob = 100; rprob = 100;
        ordy_pat = '1; vmask0 = '1; vmask1 = '1;
        clear_obs();
        @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        rst_n = 1'b1;
        model_reset();

        // Alternating single-beat packets, each preceded by an arbitration cycle.
        clear_obs();
        for (int i = 0; i < 2; i++) begin
            add_beat(0, 8'hA0 + 8'(i), 1'b1, 1'b0);
            add_beat(1, 8'hB0 + 8'(i), 1'b1, 1'b0);
        end
        repeat (8) step();
        check("alt_count", obs_src.size(), 4);
        for (int i = 0; i < obs_src.size() && i < 4; i++) begin
            check("alt_src", obs_src[i], i % 2);
            check("alt_cyc", obs_cyc[i], 2 * i + 1);
        end

`ifndef MUX2_ARB_BURST_LIMIT_EN
        // Three-beat packet on req0 completes before the waiting req1 gets the bus.
        clear_obs();
        add_beat(0, 8'h11, 1'b0, 1'b0);
        add_beat(0, 8'h22, 1'b0, 1'b0);
        add_beat(0, 8'h33, 1'b1, 1'b0);
        add_beat(1, 8'hB1, 1'b1, 1'b0);
        repeat (6) step();
        begin
            int               es[4] = '{0, 0, 0, 1};
            logic [WIDTH-1:0] ed[4] = '{8'h11, 8'h22, 8'h33, 8'hB1};
            check("pkt_count", obs_src.size(), 4);
            for (int i = 0; i < obs_src.size() && i < 4; i++) begin
                check("pkt_src", obs_src[i], es[i]);
                check("pkt_data", obs_data[i], ed[i]);
            end
        end

        // Owner stalls three cycles mid-packet; grant is kept.
        clear_obs();
        vmask0 = 32'hFFFF_FFC7;
        for (int i = 0; i < 4; i++) add_beat(0, 8'hD0 + 8'(i), i == 3, 1'b0);
        add_beat(1, 8'hE1, 1'b1, 1'b0);
        repeat (10) step();
        vmask0 = '1;
        check("stall_count", obs_src.size(), 5);
        if (obs_src.size() == 5) begin
            check("stall_src3", obs_src[3], 0);
            check("stall_src4", obs_src[4], 1);
            check("stall_gap", obs_cyc[2] - obs_cyc[1], 4);
        end
`else
        // Burst cap of 2 yields to waiting req1, then req0 alone runs uninterrupted.
        clear_obs();
        for (int i = 0; i < 6; i++) add_beat(0, 8'hF0 + 8'(i), i == 5, 1'b0);
        add_beat(1, 8'hE1, 1'b1, 1'b0);
        repeat (10) step();
        begin
            int es[7] = '{0, 0, 1, 0, 0, 0, 0};
            check("burst_count", obs_src.size(), 7);
            for (int i = 0; i < obs_src.size() && i < 7; i++) check("burst_src", obs_src[i], es[i]);
        end
        clear_obs();
        for (int i = 0; i < 6; i++) add_beat(0, 8'hC0 + 8'(i), i == 5, 1'b0);
        repeat (7) step();
        check("solo_count", obs_src.size(), 6);
        if (obs_src.size() == 6) check("solo_span", obs_cyc[5] - obs_cyc[0], 5);
`endif

        // Downstream back-pressure during a req1 packet.
        clear_obs();
        ordy_pat = 32'hFFFF_FFFB;
        add_beat(1, 8'hC1, 1'b0, 1'b0);
        add_beat(1, 8'hC2, 1'b0, 1'b0);
        add_beat(1, 8'hC3, 1'b1, 1'b0);
        repeat (5) step();
        ordy_pat = '1;
        begin
            logic [WIDTH-1:0] ed[3] = '{8'hC1, 8'hC2, 8'hC3};
            int               ec[3] = '{1, 3, 4};
            check("bp_count", obs_src.size(), 3);
            for (int i = 0; i < obs_src.size() && i < 3; i++) begin
                check("bp_data", obs_data[i], ed[i]);
                check("bp_cyc", obs_cyc[i], ec[i]);
            end
        end

        // Reset in the middle of a req1 packet.
        clear_obs();
        add_beat(1, 8'h71, 1'b0, 1'b0);
        add_beat(1, 8'h72, 1'b0, 1'b0);
        add_beat(1, 8'h73, 1'b1, 1'b0);
        repeat (2) step();
        check("mid_sent", obs_src.size(), 1);
        req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h72; req1_last = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_sel", sel, 0);
        check("arst_rdy0", req0_ready, 0);
        check("arst_rdy1", req1_ready, 0);
        @(posedge clk);
        #2;
        check("rst_hold_rdy1", req1_ready, 0);
        check("rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        model_reset();
        q0.delete();
        q1.delete();
        clear_obs();
        add_beat(0, 8'h81, 1'b1, 1'b0);
        add_beat(1, 8'h91, 1'b1, 1'b0);
        repeat (4) step();
        check("post_rst_count", obs_src.size(), 2);
        if (obs_src.size() == 2) begin
            check("post_rst_first", obs_src[0], 0);
            check("post_rst_second", obs_src[1], 1);
        end

        // Randomized traffic checked cycle by cycle plus an end-to-end scoreboard.
        clear_obs();
        exp0.delete();
        exp1.delete();
        for (int p = 0; p < 40; p++) begin
            for (int s = 0; s < 2; s++) begin
                len = int'($urandom_range(6, 1));
                for (int b = 0; b < len; b++) add_beat(s, WIDTH'($urandom), b == len - 1, 1'b1);
            end
        end
        vprob = 70;
        rprob = 70;
        repeat (400) step();
        vprob = 100;
        rprob = 100;
        for (int i = 0; i < 800 && (q0.size() > 0 || q1.size() > 0); i++) step();
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < obs_src.size(); i++) begin
            if (obs_src[i] == 0) begin
                if (n0 < exp0.size()) check("sb_data0", obs_data[i], exp0[n0]);
                n0++;
            end else begin
                if (n1 < exp1.size()) check("sb_data1", obs_data[i], exp1[n1]);
                n1++;
            end
        end
        check("sb_count0", n0, exp0.size());
        check("sb_count1", n1, exp1.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
